// File: rtl/sdm_pkg.sv
// Shared definitions for the MASH 1-1-1 fractional-N modulator.
package sdm_pkg;
  localparam int SDM_FRAC_W  = 16;
  localparam int SDM_INT_W   = 8;
  localparam int SDM_MIN_DIV = 4;
  localparam int SDM_DEF_INT = 32;

  // The three-stage noise-shaped offset always lies in this range.
  localparam int Y_MIN = -3;
  localparam int Y_MAX = 4;

  typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/sdm_acc_stage.sv
// One first-order accumulator stage: W-bit adder with carry out and a holdable, clearable register.
module sdm_acc_stage #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         hold,
  input  logic         clr,
  output logic [W-1:0] sum_low,
  output logic         carry
);
  logic [W-1:0] acc;

  assign {carry, sum_low} = {1'b0, acc} + {1'b0, din};

  always_ff @(posedge clk) begin
    if (!rst)       acc <= '0;
    else if (clr)   acc <= '0;
    else if (!hold) acc <= sum_low;
  end
endmodule

// File: rtl/mash111_sdm.sv
// Third-order MASH 1-1-1 delta-sigma modulator producing one divider ratio per divider cycle.
module mash111_sdm
  import sdm_pkg::*;
#(
  parameter int FRAC_W  = SDM_FRAC_W,
  parameter int INT_W   = SDM_INT_W,
  parameter int MIN_DIV = SDM_MIN_DIV,
  parameter int DEF_INT = SDM_DEF_INT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [INT_W-1:0]  cfg_int,
  input  logic [FRAC_W-1:0] cfg_frac,
  input  logic              cfg_clr,
  output logic [INT_W-1:0]  div_ratio,
  output logic              div_valid,
  output logic              sat_err
);
  localparam int YW = INT_W + 2;

  state_t            state;
  logic [INT_W-1:0]  int_reg, sh_int;
  logic [FRAC_W-1:0] frac_reg, sh_frac;
  logic              sh_clr, pend, rdy_en;
  logic              c2_d, c3_d, c3_dd;

  logic              step, accept, hist_clr;
  logic [FRAC_W-1:0] s1_low, s2_low, s3_low;
  logic              c1, c2, c3;
  logic signed [YW-1:0] y, raw;
  logic [INT_W-1:0]  ratio_step;
  logic              clamped;

  // The step is taken only while staying in RUN; the edge that leaves RUN behaves as IDLE.
  assign step      = (state == RUN) && en;
  assign cfg_ready = rdy_en && !pend;
  assign accept    = cfg_valid && cfg_ready;
  assign hist_clr  = pend && sh_clr;

  sdm_acc_stage #(.W(FRAC_W)) u_st1 (
    .clk(clk), .rst(rst), .din(frac_reg), .hold(!step), .clr(hist_clr),
    .sum_low(s1_low), .carry(c1)
  );
  sdm_acc_stage #(.W(FRAC_W)) u_st2 (
    .clk(clk), .rst(rst), .din(s1_low), .hold(!step), .clr(hist_clr),
    .sum_low(s2_low), .carry(c2)
  );
  sdm_acc_stage #(.W(FRAC_W)) u_st3 (
    .clk(clk), .rst(rst), .din(s2_low), .hold(!step), .clr(hist_clr),
    .sum_low(s3_low), .carry(c3)
  );

  // Modular YW-bit arithmetic yields the two's-complement offset directly.
  always_comb begin
    y = YW'(c1) + YW'(c2) - YW'(c2_d) + YW'(c3) - (YW'(c3_d) << 1) + YW'(c3_dd);
    raw = y + $signed(YW'(int_reg));
    clamped = 1'b0;
    ratio_step = raw[INT_W-1:0];
    if (raw < $signed(YW'(MIN_DIV))) begin
      ratio_step = INT_W'(MIN_DIV);
      clamped    = 1'b1;
    end else if (raw > $signed(YW'((2 ** INT_W) - 1))) begin
      ratio_step = '1;
      clamped    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      int_reg   <= INT_W'(DEF_INT);
      frac_reg  <= '0;
      sh_int    <= '0;
      sh_frac   <= '0;
      sh_clr    <= 1'b0;
      pend      <= 1'b0;
      rdy_en    <= 1'b0;
      c2_d      <= 1'b0;
      c3_d      <= 1'b0;
      c3_dd     <= 1'b0;
      div_ratio <= INT_W'(DEF_INT);
      div_valid <= 1'b0;
      sat_err   <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      state  <= en ? RUN : IDLE;

      if (step) begin
        div_ratio <= ratio_step;
        div_valid <= 1'b1;
        c2_d      <= c2;
        c3_d      <= c3;
        c3_dd     <= c3_d;
        if (clamped) sat_err <= 1'b1;
      end else begin
        div_ratio <= int_reg;
        div_valid <= 1'b0;
      end

      if (hist_clr) begin
        c2_d  <= 1'b0;
        c3_d  <= 1'b0;
        c3_dd <= 1'b0;
      end

      // Commit wins over a clamp on the same edge.
      if (pend) begin
        int_reg  <= sh_int;
        frac_reg <= sh_frac;
        sat_err  <= 1'b0;
        pend     <= 1'b0;
      end

      if (accept) begin
        sh_int  <= cfg_int;
        sh_frac <= cfg_frac;
        sh_clr  <= cfg_clr;
        pend    <= 1'b1;
      end
    end
  end
endmodule
